vgacon_term_writer: RTL

- Terminal-style front end for the 3x10 VGA text console: consumes a byte stream (valid/ready) and drives the console text buffer's write port with {color_sel, ascii7} cells.
- Maintains cursor, current colour bit, line wrap, control codes, full-screen clear and scroll-up.
- Sits directly upstream of the text buffer / character renderer and replaces raw per-cell host writes.

---
 rtl/vgacon_term_writer.sv | 138 +++++++++++++
 1 files changed

// File: rtl/vgacon_term_writer.sv
// Terminal-style byte-stream front end for the VGA text console: tracks the cursor
// and colour, interprets control codes, and drives the text buffer's write port.
module vgacon_term_writer #(
   parameter int unsigned NUM_ROWS = 3,
   parameter int unsigned NUM_COLS = 10,
   parameter int unsigned ADDR_W   = 5
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic              buf_wr_en,
   output logic [ADDR_W-1:0] buf_wr_addr,
   output logic [7:0]        buf_wr_data,
   output logic [ADDR_W-1:0] buf_rd_addr,
   input  logic [7:0]        buf_rd_data,
   output logic [1:0]        cursor_row,
   output logic [3:0]        cursor_col,
   output logic              busy
);

   typedef enum logic [1:0] {
      IDLE,
      CLEAR,
      SCROLL_COPY,
      SCROLL_CLEAR
   } state_t;

   localparam logic [1:0]        LAST_ROW      = 2'(NUM_ROWS - 1);
   localparam logic [3:0]        LAST_COL      = 4'(NUM_COLS - 1);
   localparam logic [4:0]        CLEAR_LAST    = 5'(NUM_ROWS * NUM_COLS - 1);
   localparam logic [4:0]        COPY_LAST     = 5'((NUM_ROWS - 1) * NUM_COLS - 1);
   localparam logic [4:0]        SCLR_LAST     = 5'(NUM_COLS - 1);
   localparam logic [ADDR_W-1:0] COLS_A        = ADDR_W'(NUM_COLS);
   localparam logic [ADDR_W-1:0] LAST_ROW_BASE = ADDR_W'((NUM_ROWS - 1) * NUM_COLS);
   localparam logic [7:0]        SPACE         = 8'h20;

   state_t            state;
   logic [4:0]        cnt;
   logic              color_sel;
   logic [ADDR_W-1:0] cur_addr;

   always_comb begin
      cur_addr    = ADDR_W'(cursor_row) * COLS_A + ADDR_W'(cursor_col);
      in_ready    = (state == IDLE) && !rst;
      busy        = (state != IDLE);
      // Read runs one row ahead of the write, so the source row is never overwritten first.
      buf_rd_addr = (state == SCROLL_COPY && !rst) ? ADDR_W'(cnt) + COLS_A : '0;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         cnt         <= '0;
         cursor_row  <= '0;
         cursor_col  <= '0;
         color_sel   <= 1'b0;
         buf_wr_en   <= 1'b0;
         buf_wr_addr <= '0;
         buf_wr_data <= '0;
      end else begin
         buf_wr_en <= 1'b0;
         case (state)
            IDLE: begin
               cnt <= '0;
               if (in_valid) begin
                  if (in_data >= 8'h20 && in_data <= 8'h7E) begin
                     buf_wr_en   <= 1'b1;
                     buf_wr_addr <= cur_addr;
                     buf_wr_data <= {color_sel, in_data[6:0]};
                     if (cursor_col == LAST_COL) begin
                        cursor_col <= '0;
                        if (cursor_row == LAST_ROW) state <= SCROLL_COPY;
                        else cursor_row <= cursor_row + 2'd1;
                     end else begin
                        cursor_col <= cursor_col + 4'd1;
                     end
                  end else begin
                     case (in_data)
                        8'h0A: begin
                           cursor_col <= '0;
                           if (cursor_row == LAST_ROW) state <= SCROLL_COPY;
                           else cursor_row <= cursor_row + 2'd1;
                        end
                        8'h0D: cursor_col <= '0;
                        8'h08: if (cursor_col != '0) cursor_col <= cursor_col - 4'd1;
                        8'h0C: begin
                           state      <= CLEAR;
                           cursor_row <= '0;
                           cursor_col <= '0;
                        end
                        8'h0E: color_sel <= 1'b0;
                        8'h0F: color_sel <= 1'b1;
                        default: ;
                     endcase
                  end
               end
            end
            CLEAR: begin
               buf_wr_en   <= 1'b1;
               buf_wr_addr <= ADDR_W'(cnt);
               buf_wr_data <= SPACE;
               if (cnt == CLEAR_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            SCROLL_COPY: begin
               buf_wr_en   <= 1'b1;
               buf_wr_addr <= ADDR_W'(cnt);
               buf_wr_data <= buf_rd_data;
               if (cnt == COPY_LAST) begin
                  state <= SCROLL_CLEAR;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            SCROLL_CLEAR: begin
               buf_wr_en   <= 1'b1;
               buf_wr_addr <= LAST_ROW_BASE + ADDR_W'(cnt);
               buf_wr_data <= SPACE;
               if (cnt == SCLR_LAST) begin
                  state <= IDLE;
                  cnt   <= '0;
               end else begin
                  cnt <= cnt + 5'd1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
